// File: rtl/ccis_tx_req_buffer.sv
// Purpose: FIFO between AFU request issue and the FIU TX channel, with registered outputs.
// Latency: a request accepted in cycle t appears on fiu_valid in cycle t+2 when the FIU is not stalling.
// Backpressure: afu_almostFull is registered with ALMFULL_SLACK headroom; a request that arrives when full is dropped and flagged.
module ccis_tx_req_buffer #(
  parameter int N_ENTRIES     = 8,
  parameter int ALMFULL_SLACK = 4,
  parameter int N_KINDS       = 2,
  parameter int HDR_WIDTH     = 99,
  parameter int DATA_WIDTH    = 512,
  parameter logic [HDR_WIDTH-1:0] RSVD_MASK = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_KINDS-1:0]                 afu_valid,
  input  logic [HDR_WIDTH-1:0]               afu_hdr,
  input  logic [DATA_WIDTH-1:0]              afu_data,
  output logic                               afu_almostFull,
  output logic [N_KINDS-1:0]                 fiu_valid,
  output logic [HDR_WIDTH-1:0]               fiu_hdr,
  output logic [DATA_WIDTH-1:0]              fiu_data,
  input  logic                               fiu_almostFull,
  output logic [$clog2(N_ENTRIES+1)-1:0]     occupancy,
  output logic                               overflow_err
);

  localparam int PW = $clog2(N_ENTRIES);
  localparam int OW = $clog2(N_ENTRIES + 1);
  localparam logic [OW-1:0] FULL_CNT  = OW'(N_ENTRIES);
  localparam logic [OW-1:0] AF_THRESH = OW'(N_ENTRIES - ALMFULL_SLACK);

  // Storage carries no reset: entries become invalid simply by resetting the pointers.
  logic [N_KINDS-1:0]    mem_valid [N_ENTRIES];
  logic [HDR_WIDTH-1:0]  mem_hdr   [N_ENTRIES];
  logic [DATA_WIDTH-1:0] mem_data  [N_ENTRIES];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] occ_nxt;
  logic          req;
  logic          is_full;
  logic          do_enq;
  logic          do_deq;

  // Enqueue/dequeue decisions use start-of-cycle occupancy; a full buffer drops even if it drains this cycle.
  always_comb begin
    req     = |afu_valid;
    is_full = (occupancy == FULL_CNT);
    do_enq  = req && !is_full;
    do_deq  = (occupancy != '0) && !fiu_almostFull;
    occ_nxt = occupancy;
    if (do_enq && !do_deq) begin
      occ_nxt = occupancy + OW'(1);
    end else if (!do_enq && do_deq) begin
      occ_nxt = occupancy - OW'(1);
    end
  end

  // Write accepted requests verbatim into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (!reset && do_enq) begin
      mem_valid[wr_ptr] <= afu_valid;
      mem_hdr[wr_ptr]   <= afu_hdr;
      mem_data[wr_ptr]  <= afu_data;
    end
  end

  // Pointers, occupancy, flags and the output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occupancy      <= '0;
      afu_almostFull <= 1'b0;
      overflow_err   <= 1'b0;
      fiu_valid      <= '0;
      fiu_hdr        <= '0;
      fiu_data       <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      occupancy      <= occ_nxt;
      afu_almostFull <= (occ_nxt >= AF_THRESH);
      if (req && is_full) begin
        overflow_err <= 1'b1;
      end
      // Header and data hold when idle; only the valids return to zero.
      if (do_deq) begin
        fiu_valid <= mem_valid[rd_ptr];
        fiu_hdr   <= mem_hdr[rd_ptr] & ~RSVD_MASK;
        fiu_data  <= mem_data[rd_ptr];
      end else begin
        fiu_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ccis_tx_req_buffer.sv
// Purpose: directed checks of ccis_tx_req_buffer, plus a reference-queue check for a throttled stream.
// Latency: inputs are applied before each rising edge and outputs are sampled 1 time unit after it.
// Backpressure: the stream phase issues only while afu_almostFull is low and toggles fiu_almostFull.
module tb_ccis_tx_req_buffer;

  typedef struct packed {
    logic [1:0]   v;
    logic [98:0]  h;
    logic [511:0] d;
  } req_t;

  logic         clk;
  logic         reset;
  logic [1:0]   afu_valid;
  logic [98:0]  afu_hdr;
  logic [511:0] afu_data;
  logic         fiu_almostFull;

  logic         afu_almostFull, m_afu_almostFull;
  logic [1:0]   fiu_valid, m_fiu_valid;
  logic [98:0]  fiu_hdr, m_fiu_hdr;
  logic [511:0] fiu_data, m_fiu_data;
  logic [3:0]   occupancy, m_occupancy;
  logic         overflow_err, m_overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  ccis_tx_req_buffer dut (
    .clk(clk), .reset(reset),
    .afu_valid(afu_valid), .afu_hdr(afu_hdr), .afu_data(afu_data),
    .afu_almostFull(afu_almostFull),
    .fiu_valid(fiu_valid), .fiu_hdr(fiu_hdr), .fiu_data(fiu_data),
    .fiu_almostFull(fiu_almostFull),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  ccis_tx_req_buffer #(.RSVD_MASK(99'hF)) dut_m (
    .clk(clk), .reset(reset),
    .afu_valid(afu_valid), .afu_hdr(afu_hdr), .afu_data(afu_data),
    .afu_almostFull(m_afu_almostFull),
    .fiu_valid(m_fiu_valid), .fiu_hdr(m_fiu_hdr), .fiu_data(m_fiu_data),
    .fiu_almostFull(fiu_almostFull),
    .occupancy(m_occupancy), .overflow_err(m_overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of AFU inputs, then land just after the closing edge.
  task automatic cyc(input logic [1:0] v, input logic [98:0] h, input logic [511:0] d);
    afu_valid = v;
    afu_hdr   = h;
    afu_data  = d;
    @(posedge clk);
    #1;
  endtask

  req_t         q[$];
  req_t         it;
  logic [98:0]  ones;
  logic [1:0]   exp_v;
  logic [98:0]  exp_h;
  logic [511:0] exp_d;
  logic [1:0]   sv;
  logic [98:0]  sh;
  logic [511:0] sd;
  int           sent;
  int           seen;
  int           stray;
  int           cyc_n;
  int           occ_max;
  logic         deq;

  initial begin
    reset          = 1'b1;
    fiu_almostFull = 1'b0;
    afu_valid      = '0;
    afu_hdr        = '0;
    afu_data       = '0;
    ones           = '1;

    // Reset state
    cyc(2'b00, '0, '0);
    cyc(2'b11, 99'h3, 512'h3);
    chk("rst_occ", 512'(occupancy), 0);
    chk("rst_fiu_valid", 512'(fiu_valid), 0);
    chk("rst_afu_af", 512'(afu_almostFull), 0);
    chk("rst_ovf", 512'(overflow_err), 0);
    chk("rst_hdr", 512'(fiu_hdr), 0);
    chk("rst_data", fiu_data, 0);
    reset = 1'b0;

    // Single request: occupancy 1 then output at t+2 for exactly one cycle
    cyc(2'b01, 99'h5, 512'hAB);
    chk("lat_occ_t1", 512'(occupancy), 1);
    chk("lat_valid_t1", 512'(fiu_valid), 0);
    cyc(2'b00, '0, '0);
    chk("lat_valid_t2", 512'(fiu_valid), 512'h1);
    chk("lat_hdr_t2", 512'(fiu_hdr), 512'h5);
    chk("lat_data_t2", fiu_data, 512'hAB);
    chk("lat_occ_t2", 512'(occupancy), 0);
    chk("lat_mhdr_t2", 512'(m_fiu_hdr), 0);
    cyc(2'b00, '0, '0);
    chk("lat_valid_t3", 512'(fiu_valid), 0);
    chk("lat_hdr_hold", 512'(fiu_hdr), 512'h5);

    // Stalled FIU: almost-full threshold at 4
    fiu_almostFull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(i[0] ? 2'b10 : 2'b01, 99'(16 + i), 512'(i));
      if (i == 2) chk("af_below_thresh", 512'(afu_almostFull), 0);
    end
    chk("af_at_thresh", 512'(afu_almostFull), 1);
    chk("af_occ4", 512'(occupancy), 4);
    chk("af_valid_stalled", 512'(fiu_valid), 0);

    // Fill to 8, then a 9th request is dropped and overflow sticks
    for (int i = 4; i < 8; i++) cyc(i[0] ? 2'b10 : 2'b01, 99'(16 + i), 512'(i));
    chk("full_occ8", 512'(occupancy), 8);
    chk("full_no_ovf", 512'(overflow_err), 0);
    cyc(2'b01, 99'h18, 512'h18);
    chk("ovf_set", 512'(overflow_err), 1);
    chk("ovf_occ8", 512'(occupancy), 8);
    cyc(2'b00, '0, '0);
    chk("ovf_sticky", 512'(overflow_err), 1);
    fiu_almostFull = 1'b0;
    for (int j = 0; j < 8; j++) begin
      cyc(2'b00, '0, '0);
      chk($sformatf("drain_valid%0d", j), 512'(fiu_valid), j[0] ? 512'h2 : 512'h1);
      chk($sformatf("drain_hdr%0d", j), 512'(fiu_hdr), 512'(16 + j));
    end
    cyc(2'b00, '0, '0);
    chk("drain_done_valid", 512'(fiu_valid), 0);
    chk("drain_done_occ", 512'(occupancy), 0);
    chk("drain_done_af", 512'(afu_almostFull), 0);
    chk("drain_ovf_sticky", 512'(overflow_err), 1);
    reset = 1'b1;
    cyc(2'b00, '0, '0);
    reset = 1'b0;
    chk("ovf_cleared", 512'(overflow_err), 0);

    // Reserved header bits
    cyc(2'b01, ones, 512'h1);
    cyc(2'b00, '0, '0);
    chk("mask_valid", 512'(m_fiu_valid), 512'h1);
    chk("mask_hdr", 512'(m_fiu_hdr), 512'(ones & ~99'hF));
    chk("nomask_hdr", 512'(fiu_hdr), 512'(ones));

    // Throttled stream of 20 against a reference queue
    sent = 0; seen = 0; cyc_n = 0; occ_max = 0;
    q.delete();
    while ((sent < 20 || q.size() != 0 || fiu_valid != 2'b00) && cyc_n < 300) begin
      fiu_almostFull = ((cyc_n / 3) % 2) == 0;
      sv = 2'b00; sh = '0; sd = '0;
      if (sent < 20 && !afu_almostFull) begin
        sv = (sent % 5 == 0) ? 2'b11 : (sent[0] ? 2'b10 : 2'b01);
        sh = 99'(256 + sent);
        sd = 512'(1000 + 7 * sent);
        sent++;
      end
      deq   = (q.size() != 0) && !fiu_almostFull;
      exp_v = 2'b00; exp_h = '0; exp_d = '0;
      if (sv != 2'b00 && q.size() < 8) q.push_back('{v: sv, h: sh, d: sd});
      if (deq) begin
        it = q.pop_front();
        exp_v = it.v; exp_h = it.h; exp_d = it.d;
      end
      cyc(sv, sh, sd);
      cyc_n++;
      chk($sformatf("str_valid_c%0d", cyc_n), 512'(fiu_valid), 512'(exp_v));
      if (exp_v != 2'b00) begin
        chk($sformatf("str_hdr_c%0d", cyc_n), 512'(fiu_hdr), 512'(exp_h));
        chk($sformatf("str_data_c%0d", cyc_n), fiu_data, exp_d);
      end
      chk($sformatf("str_occ_c%0d", cyc_n), 512'(occupancy), 512'(q.size()));
      if (fiu_valid != 2'b00) seen++;
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
    end
    chk("str_timeout", 512'(cyc_n >= 300), 0);
    chk("str_count", 512'(seen), 20);
    chk("str_occ_max", 512'(occ_max > 8), 0);
    chk("str_no_ovf", 512'(overflow_err), 0);

    // Reset mid-stream with 5 queued discards everything
    fiu_almostFull = 1'b1;
    for (int i = 0; i < 5; i++) cyc(2'b01, 99'(48 + i), 512'(48 + i));
    chk("mid_occ5", 512'(occupancy), 5);
    reset = 1'b1;
    fiu_almostFull = 1'b0;
    cyc(2'b01, 99'h99, 512'h99);
    reset = 1'b0;
    chk("mid_rst_occ", 512'(occupancy), 0);
    chk("mid_rst_valid", 512'(fiu_valid), 0);
    chk("mid_rst_af", 512'(afu_almostFull), 0);
    cyc(2'b10, 99'h77, 512'h77);
    chk("post_rst_occ1", 512'(occupancy), 1);
    cyc(2'b00, '0, '0);
    chk("post_rst_valid", 512'(fiu_valid), 512'h2);
    chk("post_rst_hdr", 512'(fiu_hdr), 512'h77);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(2'b00, '0, '0);
      if (fiu_valid != 2'b00) stray++;
    end
    chk("post_rst_no_stale", 512'(stray), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ccis_tx_req_buffer.md
CCIS_TX_REQ_BUFFER -- requirements
Module: ccis_tx_req_buffer

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 8, FIFO depth (power of 2, >= 4).
REQ-002 SHALL have parameter ALMFULL_SLACK, default 4, count of requests the AFU may issue after afu_almostFull asserts (1 <= ALMFULL_SLACK < N_ENTRIES).
REQ-003 SHALL have parameter N_KINDS, default 2, count of per-kind valid bits (e.g. wrValid, intrValid).
REQ-004 SHALL have parameter HDR_WIDTH, default 99, request header width.
REQ-005 SHALL have parameter DATA_WIDTH, default 512, request data width.
REQ-006 SHALL have parameter RSVD_MASK, width HDR_WIDTH, default 0, header bits forced to 0 on output.
REQ-007 clk  input  1  sole clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 afu_valid  input  N_KINDS  per-kind request valids; all-zero means no request.
REQ-010 afu_hdr  input  HDR_WIDTH  request header.
REQ-011 afu_data  input  DATA_WIDTH  request data.
REQ-012 afu_almostFull  output  1  registered back-pressure to the AFU.
REQ-013 fiu_valid  output  N_KINDS  registered per-kind valids toward the FIU.
REQ-014 fiu_hdr  output  HDR_WIDTH  registered header, RSVD_MASK bits zeroed.
REQ-015 fiu_data  output  DATA_WIDTH  registered data.
REQ-016 fiu_almostFull  input  1  FIU back-pressure.
REQ-017 occupancy  output  clog2(N_ENTRIES+1)  entries held in FIFO, excluding output register.
REQ-018 overflow_err  output  1  sticky flag: a request was dropped.

Function
REQ-019 Enqueue SHALL occur in any cycle where afu_valid is non-zero and occupancy (start of cycle) < N_ENTRIES; afu_valid, afu_hdr, afu_data stored verbatim (multi-hot valids not checked).
REQ-020 When afu_valid is non-zero and occupancy == N_ENTRIES, the request SHALL be dropped and overflow_err set to 1 next cycle, even if a dequeue occurs that cycle.
REQ-021 Dequeue SHALL occur in any cycle where occupancy > 0 and fiu_almostFull == 0; head entry loaded into output registers, fiu_valid = stored valids the next cycle.
REQ-022 In any cycle with no dequeue, the next-cycle fiu_valid SHALL be all-zero; fiu_hdr/fiu_data hold their previous values.
REQ-023 fiu_hdr SHALL equal stored header AND NOT RSVD_MASK.
REQ-024 Latency: request presented in cycle t to empty buffer with fiu_almostFull low SHALL appear on fiu_valid in cycle t+2.
REQ-025 Throughput: one enqueue and one dequeue per cycle sustained; simultaneous enqueue and dequeue leave occupancy unchanged.
REQ-026 Order SHALL be strict FIFO across all kinds.
REQ-027 Read/write pointers SHALL be log2(N_ENTRIES) bits and wrap modulo N_ENTRIES.
REQ-028 afu_almostFull SHALL be 1 in cycle t+1 iff occupancy at end of cycle t (after that cycle's enqueue/dequeue) >= N_ENTRIES - ALMFULL_SLACK.
REQ-029 A compliant AFU (stops within ALMFULL_SLACK requests of afu_almostFull) SHALL never cause overflow_err.
REQ-030 overflow_err SHALL stay 1 until reset.

Reset
REQ-031 While reset is high: pointers and occupancy 0, all stored entries discarded, fiu_valid 0, afu_almostFull 0, overflow_err 0, fiu_hdr/fiu_data 0.
REQ-032 Requests presented in a reset cycle SHALL be discarded; enqueue resumes in the first cycle with reset low.
REQ-033 Reset asserted mid-stream SHALL discard queued and output-registered requests; none appear on fiu_valid afterwards.

Verification (N_ENTRIES=8, ALMFULL_SLACK=4, N_KINDS=2)
REQ-034 Single write kind 2'b01, hdr 0x5, fiu_almostFull=0 at cycle 10 -> fiu_valid=2'b01, fiu_hdr=0x5 in cycle 12 only; occupancy 1 in cycle 11, 0 in cycle 12.
REQ-035 fiu_almostFull=1, 4 back-to-back requests -> afu_almostFull=1 the cycle after the 4th, occupancy 4, fiu_valid stays 0.
REQ-036 fiu_almostFull=1, 9 back-to-back requests -> 9th dropped, overflow_err=1 next cycle and sticky; release -> exactly 8 requests out in order.
REQ-037 RSVD_MASK=0xF, hdr all-ones -> fiu_hdr low 4 bits 0, others 1.
REQ-038 Continuous stream of 20 requests, fiu_almostFull toggling every 3 cycles -> all 20 emerge in order, no gaps while eligible, occupancy never > 8.
REQ-039 reset for 1 cycle with 5 queued -> next cycle occupancy 0, fiu_valid 0, afu_almostFull 0; no old requests ever emitted.
